cplx_conj_scheduler: RTL and testbench

CPLX_CONJ_SCHEDULER -- requirements
Module: cplx_conj_scheduler

---
 rtl/cplx_pkg.sv | 35 +++
 rtl/cplx_conj_scheduler_if.sv | 28 ++
 rtl/cplx_rr_arbiter.sv | 31 +++
 rtl/cplx_conj_scheduler.sv | 79 +++++++
 tb/tb_cplx_conj_scheduler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cplx_pkg.sv
// Shared constants and the sign-manipulation helper for the complex conjugate scheduler.
package cplx_pkg;

    localparam int CW      = 64;
    localparam int HALF    = CW / 2;
    localparam int SIGN_RE = 63;
    localparam int SIGN_IM = 31;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_CONJ = 2'b01,
        OP_NEG  = 2'b10,
        OP_MULJ = 2'b11
    } op_e;

    // Pure bit manipulation: only sign bits move, so NaN/Inf/denormal payloads survive.
    function automatic logic [CW-1:0] apply_op(input logic [1:0] op, input logic [CW-1:0] d);
        logic [CW-1:0] r;
        r = d;
        case (op)
            OP_CONJ: r[SIGN_IM] = ~d[SIGN_IM];
            OP_NEG: begin
                r[SIGN_RE] = ~d[SIGN_RE];
                r[SIGN_IM] = ~d[SIGN_IM];
            end
            OP_MULJ: begin
                r = {d[HALF-1:0], d[CW-1:HALF]};
                r[SIGN_RE] = ~r[SIGN_RE];
            end
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cplx_conj_scheduler_if.sv
// Requester and result bus of the complex conjugate scheduler.
interface cplx_conj_scheduler_if
    import cplx_pkg::*;
#(
    parameter int N_REQ = 4
) ();
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*CW-1:0] req_data;
    logic [N_REQ*2-1:0]  req_op;
    logic                out_valid;
    logic                out_ready;
    logic [CW-1:0]       out_data;
    logic [ID_W-1:0]     out_id;
    logic                busy;

    modport master (
        output req_valid, req_data, req_op, out_ready,
        input  req_ready, out_valid, out_data, out_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_op, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/cplx_rr_arbiter.sv
// Round-robin one-hot grant: search starts at ptr and wraps modulo N_REQ.
module cplx_rr_arbiter #(
    parameter int  N_REQ = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant
);
    logic            found;
    logic [ID_W-1:0] idx;
    int              pos;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) pos -= N_REQ;
            idx = pos[ID_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        if (!enable) grant = '0;
    end
endmodule

// File: rtl/cplx_conj_scheduler.sv
// Arbitrates N_REQ complex operands into one sign-manipulation pipeline of PIPE_DEPTH stages.
module cplx_conj_scheduler
    import cplx_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int PIPE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cplx_conj_scheduler_if.slave  bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PIPE_DEPTH-1:0]           vld_pipe;
    logic [PIPE_DEPTH-1:0][CW-1:0]   data_pipe;
    logic [PIPE_DEPTH-1:0][ID_W-1:0] id_pipe;
    logic [ID_W-1:0]                 ptr;
    logic [ID_W-1:0]                 gidx;
    logic [ID_W-1:0]                 ptr_nxt;
    logic [N_REQ-1:0]                grant;
    logic [CW-1:0]                   sel_data;
    logic [1:0]                      sel_op;
    logic                            adv;
    logic                            xfer;

    assign adv = !vld_pipe[PIPE_DEPTH-1] || bus.out_ready;

    // Gating with rst_n keeps req_ready low while reset is held.
    cplx_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (bus.req_valid),
        .ptr    (ptr),
        .enable (adv && rst_n),
        .grant  (grant)
    );

    assign xfer = |grant;

    always_comb begin
        gidx     = '0;
        sel_data = '0;
        sel_op   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gidx     = ID_W'(i);
                sel_data = bus.req_data[i*CW +: CW];
                sel_op   = bus.req_op[2*i +: 2];
            end
        end
    end

    assign ptr_nxt = (gidx == ID_W'(N_REQ-1)) ? '0 : gidx + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
            id_pipe   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) ptr <= ptr_nxt;
            if (adv) begin
                vld_pipe[0]  <= xfer;
                data_pipe[0] <= xfer ? apply_op(sel_op, sel_data) : '0;
                id_pipe[0]   <= gidx;
                for (int s = 1; s < PIPE_DEPTH; s++) begin
                    vld_pipe[s]  <= vld_pipe[s-1];
                    data_pipe[s] <= data_pipe[s-1];
                    id_pipe[s]   <= id_pipe[s-1];
                end
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = vld_pipe[PIPE_DEPTH-1];
    assign bus.out_data  = data_pipe[PIPE_DEPTH-1];
    assign bus.out_id    = id_pipe[PIPE_DEPTH-1];
    assign bus.busy      = |vld_pipe;
endmodule

// File: tb/tb_cplx_conj_scheduler.sv
// Directed bench for cplx_conj_scheduler with a negedge scoreboard on accepts and pops.
module tb_cplx_conj_scheduler;
    logic clk = 1'b0;
    logic rst_n;

    cplx_conj_scheduler_if #(.N_REQ(4)) bus ();

    cplx_conj_scheduler #(.N_REQ(4), .PIPE_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cnt = 0;

    logic [63:0] exp_q[$];
    logic [1:0]  eid_q[$];
    logic [63:0] pop_data_q[$];
    logic [1:0]  pop_id_q[$];
    int          pop_cyc_q[$];

    logic        stall_prev = 1'b0;
    logic [63:0] hold_data;
    logic [1:0]  hold_id;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] d);
        case (op)
            2'b00:   return d;
            2'b01:   return d ^ 64'h00000000_80000000;
            2'b10:   return d ^ 64'h80000000_80000000;
            default: return {d[31:0] ^ 32'h80000000, d[63:32]};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [1:0] op, input logic [63:0] d);
        bus.req_op[2*i +: 2]    = op;
        bus.req_data[64*i +: 64] = d;
    endtask

    task automatic clear_logs();
        pop_data_q.delete();
        pop_id_q.delete();
        pop_cyc_q.delete();
        acc_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        step();
        step();
        exp_q.delete();
        eid_q.delete();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic drain(input int n);
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        repeat (n) step();
    endtask

    // Inputs change at posedge+1, so negedge sees exactly what the next edge will act on.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            chk("rdy_onehot", 64'($onehot0(bus.req_ready)), 64'd1);
            if (stall_prev) begin
                chk("hold_data", bus.out_data, hold_data);
                chk("hold_id", 64'(bus.out_id), 64'(hold_id));
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_q.push_back(model(bus.req_op[2*i +: 2], bus.req_data[64*i +: 64]));
                    eid_q.push_back(2'(i));
                    acc_cnt++;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    chk("sb_data", bus.out_data, exp_q.pop_front());
                    chk("sb_id", 64'(bus.out_id), 64'(eid_q.pop_front()));
                end
                pop_data_q.push_back(bus.out_data);
                pop_id_q.push_back(bus.out_id);
                pop_cyc_q.push_back(cyc);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            hold_data  = bus.out_data;
            hold_id    = bus.out_id;
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_data  = '0;
        bus.req_op    = '0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_id", 64'(bus.out_id), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);

        // Conjugate from req0, latency of PIPE_DEPTH edges.
        do_reset();
        bus.out_ready = 1'b1;
        set_lane(0, 2'b01, 64'h3F800000_40000000);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("conj_ready", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = '0;
        step();
        step();
        @(negedge clk);
        chk("lat_early", 64'(bus.out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        chk("conj_data", bus.out_data, 64'h3F800000_C0000000);
        chk("conj_id", 64'(bus.out_id), 64'd0);
        drain(3);

        // Lone req2: multiply-by-j then negate on back-to-back cycles.
        clear_logs();
        set_lane(2, 2'b11, 64'h3F800000_40000000);
        bus.req_valid = 4'b0100;
        step();
        set_lane(2, 2'b10, 64'h3F800000_40000000);
        step();
        drain(8);
        chk("lone_pops", 64'(pop_data_q.size()), 64'd2);
        if (pop_data_q.size() >= 2) begin
            chk("mulj_data", pop_data_q[0], 64'hC0000000_3F800000);
            chk("mulj_id", 64'(pop_id_q[0]), 64'd2);
            chk("neg_data", pop_data_q[1], 64'hBF800000_C0000000);
            chk("neg_id", 64'(pop_id_q[1]), 64'd2);
        end

        // All four valid for 8 cycles: strict rotation, one result per cycle.
        do_reset();
        set_lane(0, 2'b01, 64'h3F800000_40000000);
        set_lane(1, 2'b10, 64'h7F800000_00000001);
        set_lane(2, 2'b11, 64'h12345678_9ABCDEF0);
        set_lane(3, 2'b00, 64'h7FC00001_FF800000);
        bus.out_ready = 1'b1;
        bus.req_valid = 4'hF;
        repeat (8) step();
        drain(8);
        chk("rr_accepts", 64'(acc_cnt), 64'd8);
        chk("rr_pops", 64'(pop_id_q.size()), 64'd8);
        for (int i = 0; i < pop_id_q.size() && i < 8; i++) begin
            chk("rr_id", 64'(pop_id_q[i]), 64'(i % 4));
            chk("rr_rate", 64'(pop_cyc_q[i] - pop_cyc_q[0]), 64'(i));
        end

        // Fill then stall five cycles with every requester still asking.
        do_reset();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", 64'(bus.req_ready), 64'd0);
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            step();
        end
        drain(8);
        chk("stall_accepts", 64'(acc_cnt), 64'd4);
        chk("stall_pops", 64'(pop_id_q.size()), 64'd4);
        chk("stall_left", 64'(exp_q.size()), 64'd0);

        // Reset mid-flight with three entries, then ptr must restart at 0.
        do_reset();
        bus.out_ready = 1'b1;
        set_lane(1, 2'b01, 64'hDEADBEEF_CAFEF00D);
        bus.req_valid = 4'b0010;
        repeat (3) step();
        bus.req_valid = '0;
        step();
        chk("flight_valid", 64'(bus.out_valid), 64'd1);
        chk("flight_busy", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_out_data", bus.out_data, 64'd0);
        exp_q.delete();
        eid_q.delete();
        step();
        rst_n = 1'b1;
        clear_logs();
        set_lane(0, 2'b00, 64'h01234567_89ABCDEF);
        bus.req_valid = 4'b0011;
        @(negedge clk);
        chk("restart_grant", 64'(bus.req_ready), 64'd1);
        step();
        drain(8);
        chk("restart_pops", 64'(pop_id_q.size()), 64'd1);
        if (pop_id_q.size() >= 1) chk("restart_id", 64'(pop_id_q[0]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
